add2_and_clip_axi: RTL and testbench
====================================

Name: add2_and_clip_axi

Overview:
- Parametrised successor to the registered two-input add-and-clip.
- Joins two multi-channel sample streams with valid/ready handshakes and adds them lane by lane at full precision.
- Clips each lane to signed WIDTH bits and emits the result through a 2-stage pipeline that supports backpressure.
- Sits in the DSP datapath, for example summing I/Q or multi-antenna streams ahead of a DUC or DDC.

Parameters:
- WIDTH, 16, signed two's-complement sample width per lane (min 2).
- NUM_CH, 2, number of lanes per beat (min 1).
- PIPE_STAGES, 2, pipeline depth; legal values 1 or 2. With 1, add and clip share a single register stage.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- i0_tdata  input  NUM_CH*WIDTH  stream 0 samples; lane k at bits [k*WIDTH +: WIDTH].
- i0_tlast  input  1  stream 0 end-of-packet.
- i0_tvalid  input  1  stream 0 valid.
- i0_tready  output  1  stream 0 ready.
- i1_tdata  input  NUM_CH*WIDTH  stream 1 samples, same lane layout.
- i1_tlast  input  1  stream 1 end-of-packet.
- i1_tvalid  input  1  stream 1 valid.
- i1_tready  output  1  stream 1 ready.
- o_tdata  output  NUM_CH*WIDTH  clipped sums.
- o_tlast  output  1  end-of-packet.
- o_tclip  output  NUM_CH  per-lane clip flag, aligned with o_tdata.
- o_tvalid  output  1  output valid.
- o_tready  input  1  downstream ready.
- sat_clr  input  1  clears the saturation counter.
- sat_count  output  32  saturation event count.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high on rst.
- Reset values: every stage valid bit = 0, so o_tvalid = 0. o_tdata, o_tclip, o_tlast and sat_count = 0. i0_tready and i1_tready = 0 while rst is asserted.
- Join rule: a beat is consumed only when i0_tvalid & i1_tvalid & s1_ready.
  - i0_tready = i1_tready = i0_tvalid & i1_tvalid & s1_ready.
  - Neither stream is ever consumed alone. A lone valid stalls with its data held.
- Stage readiness: sN_ready = ~sN_valid | s(N+1)_ready. The last stage's downstream ready is o_tready.
  - Full-throughput: one beat per cycle when o_tready is held high.
  - No combinational path from o_tready to i*_tready beyond this ready chain.
- Stage 1 (add): register the sign-extended sum sum_k = i0_k + i1_k at WIDTH+1 bits per lane, plus tlast = i0_tlast | i1_tlast.
- Stage 2 (clip), per lane:
  - If the two MSBs of sum_k differ, clip to 2^(WIDTH-1)-1 when positive, or -2^(WIDTH-1) when negative, and set o_tclip[k] = 1.
  - Otherwise output sum_k[WIDTH-1:0] and set o_tclip[k] = 0.
- Latency: PIPE_STAGES cycles from input handshake to o_tvalid, with no backpressure.
- Backpressure: while o_tvalid & ~o_tready, o_tdata, o_tclip and o_tlast hold stable. The pipeline fills, then i*_tready deasserts. No beat is dropped or duplicated.
- Reset mid-operation: all in-flight beats are discarded, valids clear, and the block resumes from the first handshake after rst drops.
- sat_count: increments by 1 on each output handshake (o_tvalid & o_tready) where o_tclip is non-zero.
  - Saturates at 32'hFFFF_FFFF and does not wrap.
  - sat_clr has priority over a same-cycle increment; the result is 0.

Optional Feature:
- Macro: ADD2_AND_CLIP_SAT_COUNT_EN.
- Defined: sat_count behaves as described in Behaviour.
- Undefined: the counter logic is omitted, sat_count is tied to 0, and sat_clr is ignored. Ports remain present so the interface is stable.

Decomposition:
- Package add_clip_pkg holds:
  - clip_result_t struct (data, clip).
  - Localparams SAT_CNT_W = 32 and CLIP_MAX / CLIP_MIN as functions of WIDTH.
  - Pure function clip_sum(WIDTH+1 in) returning clip_result_t.
- Sub-module add_clip_lane: one lane's add register and clip register with shared stage enables, generated NUM_CH times. The top level owns the handshake, valid bits, tlast and the counter.

Test Plan (WIDTH=16, NUM_CH=2, PIPE_STAGES=2, macro defined):
- Basic: lanes i0=(100,-5), i1=(200,-7), o_tready=1 -> two cycles later o_tdata=(300,-12), o_tclip=00, sat_count=0.
- Clip both rails: i0=(0x7000,0x9000), i1=(0x2000,0x9000) -> o_tdata=(0x7FFF,0x8000), o_tclip=11, sat_count=1.
- Join: i0_tvalid high for 3 cycles with i1_tvalid low -> i0_tready=0 and no output; raise i1_tvalid -> exactly one beat out.
- Backpressure: stream 8 beats, o_tready low for cycles 3-7 -> o_tdata stable while stalled, then all 8 beats out in order with no loss; i*_tready low after 2 beats buffered.
- Reset mid-stream: assert rst with 2 beats in flight -> o_tvalid=0 the next cycle, sat_count=0, and those beats never appear.
- Counter limits: preload near max via 2^32-1 clip beats (or force) -> holds at 0xFFFFFFFF; sat_clr together with a clip beat -> 0.

Source files
------------

// File: rtl/add_clip_pkg.sv
// add_clip_pkg
//   Shared types and helpers for the add2_and_clip_axi datapath.
//   - clip_result_t : clipped sample plus clip flag. The data field is sized for
//                     the widest supported lane, and callers keep the low WIDTH bits.
//   - SAT_CNT_W     : width of the saturation event counter.
//   - clip_max/min  : signed rails for a given sample width, as raw bit patterns.
//   - clip_sum      : clips a (width+1)-bit sum to width bits. The sum is passed
//                     sign-extended into a MAX_W+1 container, with its width given separately.
package add_clip_pkg;

  localparam int SAT_CNT_W = 32;
  localparam int MAX_W     = 64;
  localparam int IDX_W     = $clog2(MAX_W + 1);

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             clip;
  } clip_result_t;

  function automatic logic [MAX_W-1:0] clip_max(input int width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] clip_min(input int width);
    return MAX_W'(1) << (width - 1);
  endfunction

  function automatic clip_result_t clip_sum(input logic [MAX_W:0] sum, input int width);
    clip_result_t     r;
    logic [MAX_W-1:0] mask;
    logic             sgn;
    mask   = (MAX_W'(1) << width) - MAX_W'(1);
    sgn    = sum[IDX_W'(width)];
    // The top two bits of a (width+1)-bit sum disagree only when it overflowed width bits.
    r.clip = sgn ^ sum[IDX_W'(width - 1)];
    if (r.clip) begin
      r.data = sgn ? clip_min(width) : clip_max(width);
    end else begin
      r.data = sum[MAX_W-1:0] & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_clip_lane.sv
// add_clip_lane
//   One lane of the add-and-clip datapath. The lane holds no valid bits of its own,
//   and the owner drives the stage enables.
//   Ports:
//     clk_i, rst_i     clock, synchronous active-high reset
//     s1_en_i          load the add stage, or the single stage when PIPE_STAGES = 1
//     s2_en_i          load the clip stage (ignored when PIPE_STAGES = 1)
//     a_i, b_i         signed input samples
//     data_o, clip_o   clipped result and its clip flag
//   WIDTH must be between 2 and 63.
module add_clip_lane
  import add_clip_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s1_en_i,
  input  logic             s2_en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] data_o,
  output logic             clip_o
);

  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   clip_src;
  logic [MAX_W:0]   clip_ext;
  clip_result_t     res;
  logic             out_en;
  logic [WIDTH-1:0] data_q;
  logic             clip_q;
  logic             unused_res_hi;

  assign sum_d    = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
  assign clip_ext = {{(MAX_W - WIDTH){clip_src[WIDTH]}}, clip_src};
  assign res      = clip_sum(clip_ext, WIDTH);
  assign unused_res_hi = ^res.data[MAX_W-1:WIDTH];

  if (PIPE_STAGES == 2) begin : g_two
    logic [WIDTH:0] sum_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sum_q <= '0;
      end else if (s1_en_i) begin
        sum_q <= sum_d;
      end
    end
    assign clip_src = sum_q;
    assign out_en   = s2_en_i;
  end else begin : g_one
    logic unused_s2_en;
    assign unused_s2_en = s2_en_i;
    assign clip_src     = sum_d;
    assign out_en       = s1_en_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      clip_q <= 1'b0;
    end else if (out_en) begin
      data_q <= res.data[WIDTH-1:0];
      clip_q <= res.clip;
    end
  end

  assign data_o = data_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/add2_and_clip_axi.sv
// add2_and_clip_axi
//   Joins two multi-lane AXI-Stream-style sample streams, adds them lane by lane,
//   and clips each sum to signed WIDTH bits. The result passes through a
//   PIPE_STAGES-deep pipeline (1 or 2 stages) that supports backpressure.
//   Ports:
//     clk, rst                               clock, synchronous active-high reset
//     i0_tdata/tlast/tvalid, i0_tready       input stream 0, lane k at [k*WIDTH +: WIDTH]
//     i1_tdata/tlast/tvalid, i1_tready       input stream 1, same layout
//     o_tdata/tlast/tclip/tvalid, o_tready   output stream, with a per-lane clip flag
//     sat_clr, sat_count                     clear input and count of output beats that clipped
//   Optional: define ADD2_AND_CLIP_SAT_COUNT_EN to build the saturation counter.
//   When it is undefined, sat_count is tied to 0 and sat_clr is ignored.
module add2_and_clip_axi
  import add_clip_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_CH      = 2,
  parameter int PIPE_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] i0_tdata,
  input  logic                    i0_tlast,
  input  logic                    i0_tvalid,
  output logic                    i0_tready,
  input  logic [NUM_CH*WIDTH-1:0] i1_tdata,
  input  logic                    i1_tlast,
  input  logic                    i1_tvalid,
  output logic                    i1_tready,
  output logic [NUM_CH*WIDTH-1:0] o_tdata,
  output logic                    o_tlast,
  output logic [NUM_CH-1:0]       o_tclip,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  input  logic                    sat_clr,
  output logic [SAT_CNT_W-1:0]    sat_count
);

  logic s1_ready;
  logic s2_load;
  logic in_fire;

  // Both streams are consumed together or not at all.
  assign in_fire   = i0_tvalid & i1_tvalid & s1_ready & ~rst;
  assign i0_tready = in_fire;
  assign i1_tready = in_fire;

  if (PIPE_STAGES == 2) begin : g_ctl2
    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic s2_ready;

    assign s2_ready = ~s2_valid_q | o_tready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign s2_load  = s1_valid_q & s2_ready;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
      if (s1_ready) s1_valid_d = in_fire;
      if (in_fire)  s1_last_d  = i0_tlast | i1_tlast;
      if (s2_ready) s2_valid_d = s1_valid_q;
      if (s2_load)  s2_last_d  = s1_last_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
        s2_valid_q <= 1'b0;
        s2_last_q  <= 1'b0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_last_q  <= s1_last_d;
        s2_valid_q <= s2_valid_d;
        s2_last_q  <= s2_last_d;
      end
    end

    assign o_tvalid = s2_valid_q;
    assign o_tlast  = s2_last_q;
  end else begin : g_ctl1
    logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;

    assign s1_ready = ~s1_valid_q | o_tready;
    assign s2_load  = 1'b0;

    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      if (s1_ready) s1_valid_d = in_fire;
      if (in_fire)  s1_last_d  = i0_tlast | i1_tlast;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_last_q  <= s1_last_d;
      end
    end

    assign o_tvalid = s1_valid_q;
    assign o_tlast  = s1_last_q;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    add_clip_lane #(
      .WIDTH      (WIDTH),
      .PIPE_STAGES(PIPE_STAGES)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .s1_en_i(in_fire),
      .s2_en_i(s2_load),
      .a_i    (i0_tdata[k*WIDTH +: WIDTH]),
      .b_i    (i1_tdata[k*WIDTH +: WIDTH]),
      .data_o (o_tdata[k*WIDTH +: WIDTH]),
      .clip_o (o_tclip[k])
    );
  end

`ifdef ADD2_AND_CLIP_SAT_COUNT_EN
  logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr) begin
      sat_cnt_d = '0;
    end else if (o_tvalid & o_tready & (|o_tclip) & ~(&sat_cnt_q)) begin
      sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_add2_and_clip_axi.sv
module tb_add2_and_clip_axi;

  localparam int W    = 16;
  localparam int NCH  = 2;
  localparam int PIPE = 2;
  localparam int DW   = W * NCH;

`ifdef ADD2_AND_CLIP_SAT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [DW-1:0] i0_tdata, i1_tdata, o_tdata;
  logic          i0_tlast, i0_tvalid, i0_tready;
  logic          i1_tlast, i1_tvalid, i1_tready;
  logic          o_tlast, o_tvalid, o_tready;
  logic [NCH-1:0] o_tclip;
  logic          sat_clr;
  logic [31:0]   sat_count;

  add2_and_clip_axi #(.WIDTH(W), .NUM_CH(NCH), .PIPE_STAGES(PIPE)) dut (
    .clk(clk), .rst(rst),
    .i0_tdata(i0_tdata), .i0_tlast(i0_tlast), .i0_tvalid(i0_tvalid), .i0_tready(i0_tready),
    .i1_tdata(i1_tdata), .i1_tlast(i1_tlast), .i1_tvalid(i1_tvalid), .i1_tready(i1_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tclip(o_tclip), .o_tvalid(o_tvalid),
    .o_tready(o_tready), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted beat is summed with plain integer arithmetic and queued.
  typedef struct {
    logic [DW-1:0]  d;
    logic [NCH-1:0] c;
    logic           l;
    int             cyc;
  } beat_t;

  beat_t       q[$];
  logic [31:0] sat_exp = 0;
  int          cyc = 0;
  logic        rst_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output logic [DW-1:0] d, output logic [NCH-1:0] c);
    longint hi, lo, s;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    for (int k = 0; k < NCH; k++) begin
      s = longint'($signed(a[k*W +: W])) + longint'($signed(b[k*W +: W]));
      c[k] = (s > hi) || (s < lo);
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      d[k*W +: W] = W'(s);
    end
  endtask

  always @(negedge clk) begin
    int    n;
    logic  exp_rdy, exp_vld;
    beat_t nb;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_o_tdata", o_tdata, 0);
        chk("rst_o_tclip", o_tclip, 0);
        chk("rst_o_tlast", o_tlast, 0);
        chk("rst_sat_count", sat_count, 0);
      end
      chk("rst_tready", {i0_tready, i1_tready}, 0);
      q.delete();
      sat_exp = 0;
    end else begin
      n = q.size();
      exp_rdy = i0_tvalid & i1_tvalid & ((n < PIPE) | o_tready);
      chk("i0_tready", i0_tready, exp_rdy);
      chk("i1_tready", i1_tready, exp_rdy);
      exp_vld = (n > 0) && (cyc >= q[0].cyc + PIPE);
      chk("o_tvalid", o_tvalid, exp_vld);
      if (o_tvalid && n > 0) begin
        chk("o_tdata", o_tdata, q[0].d);
        chk("o_tclip", o_tclip, q[0].c);
        chk("o_tlast", o_tlast, q[0].l);
      end
      chk("sat_count", sat_count, sat_exp);
      if (o_tvalid && o_tready && n > 0) begin
        if (CNT_EN && (|q[0].c) && sat_exp != 32'hFFFF_FFFF) sat_exp = sat_exp + 1;
        void'(q.pop_front());
      end
      if (CNT_EN && sat_clr) sat_exp = 0;
      if (i0_tready && i0_tvalid && i1_tvalid) begin
        model_beat(i0_tdata, i1_tdata, nb.d, nb.c);
        nb.l   = i0_tlast | i1_tlast;
        nb.cyc = cyc;
        q.push_back(nb);
      end
    end
    rst_prev = rst;
  end

  function automatic logic [W-1:0] rnd_lane();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return {2'b01, (W-2)'($urandom)};
      2:       return {2'b10, (W-2)'($urandom)};
      default: return W'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = rnd_lane();
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic lst);
    bit ok;
    i0_tdata = d0; i1_tdata = d1; i0_tlast = lst; i1_tlast = 1'b0;
    i0_tvalid = 1'b1; i1_tvalid = 1'b1;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = i0_tready;
      tick();
    end
    chk("send_handshake", ok, 1);
    i0_tvalid = 1'b0; i1_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    o_tready = 1'b1;
    i0_tvalid = 1'b0; i1_tvalid = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0);
      tick();
    end
    chk(name, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            hs, outs, pct;
    logic [DW-1:0] held;
    bit            have;
    rst = 1'b1; sat_clr = 1'b0; o_tready = 1'b1;
    i0_tdata = '0; i1_tdata = '0; i0_tlast = 1'b0; i1_tlast = 1'b0;
    i0_tvalid = 1'b1; i1_tvalid = 1'b1;

    // Reset: readiness is held low even though both streams are valid.
    tick();
    @(negedge clk); chk("reset_i0_tready", i0_tready, 0);
    tick();
    @(negedge clk); chk("reset_o_tvalid", o_tvalid, 0); chk("reset_sat", sat_count, 0);
    tick();
    rst = 1'b0; i0_tvalid = 1'b0; i1_tvalid = 1'b0;

    // Basic sum, two-cycle latency.
    send_beat({16'hFFFB, 16'd100}, {16'hFFF9, 16'd200}, 1'b0);
    @(negedge clk); chk("basic_early", o_tvalid, 0);
    tick();
    @(negedge clk);
    chk("basic_valid", o_tvalid, 1);
    chk("basic_data", o_tdata, {16'hFFF4, 16'h012C});
    chk("basic_clip", o_tclip, 2'b00);
    chk("basic_sat", sat_count, 0);
    tick();

    // Clip on both rails.
    send_beat({16'h9000, 16'h7000}, {16'h9000, 16'h2000}, 1'b1);
    tick();
    @(negedge clk);
    chk("clip_data", o_tdata, {16'h8000, 16'h7FFF});
    chk("clip_flags", o_tclip, 2'b11);
    chk("clip_last", o_tlast, 1);
    tick();
    @(negedge clk); chk("clip_sat", sat_count, CNT_EN ? 1 : 0);
    tick();

    // Join: a lone valid stalls.
    i0_tdata = rnd_beat(); i0_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("join_lone_ready", i0_tready, 0);
      chk("join_lone_out", o_tvalid, 0);
      tick();
    end
    i1_tdata = rnd_beat(); i1_tvalid = 1'b1;
    @(negedge clk); chk("join_ready", i0_tready, 1);
    tick();
    i0_tvalid = 1'b0; i1_tvalid = 1'b0;
    outs = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_tvalid && o_tready) outs++;
      tick();
    end
    chk("join_outs", outs, 1);

    // Backpressure: only PIPE beats are accepted while the output is stalled.
    o_tready = 1'b0;
    i0_tdata = rnd_beat(); i1_tdata = rnd_beat(); i0_tvalid = 1'b1; i1_tvalid = 1'b1;
    hs = 0; have = 0; held = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_tvalid) begin
        if (have) chk("bp_hold", o_tdata, held);
        held = o_tdata; have = 1;
      end
      if (i0_tready) hs++;
      if (i0_tready) begin
        tick();
        i0_tdata = rnd_beat(); i1_tdata = rnd_beat();
      end else begin
        tick();
      end
    end
    chk("bp_accepted", hs, 2);
    o_tready = 1'b1;
    for (int k = 0; k < 50 && hs < 8; k++) begin
      @(negedge clk);
      if (i0_tready) hs++;
      tick();
      i0_tdata = rnd_beat(); i1_tdata = rnd_beat();
    end
    chk("bp_total", hs, 8);
    drain("bp_drain");

    // Reset with two beats in flight.
    o_tready = 1'b0;
    send_beat(rnd_beat(), rnd_beat(), 1'b0);
    send_beat(rnd_beat(), rnd_beat(), 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_valid", o_tvalid, 0);
    chk("midrst_sat", sat_count, 0);
    tick();
    rst = 1'b0; o_tready = 1'b1;
    outs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_tvalid) outs++;
      tick();
    end
    chk("midrst_outs", outs, 0);

    // Randomized traffic with varying backpressure.
    for (int c = 0; c < 1500; c++) begin
      bit h;
      case (c / 300)
        0: pct = 100;
        1: pct = 70;
        2: pct = 30;
        3: pct = 90;
        default: pct = 50;
      endcase
      @(negedge clk);
      h = i0_tready;
      tick();
      if (h) begin i0_tvalid = 1'b0; i1_tvalid = 1'b0; end
      if (!i0_tvalid && $urandom_range(0, 3) != 0) begin
        i0_tvalid = 1'b1; i0_tdata = rnd_beat(); i0_tlast = 1'($urandom_range(0, 1));
      end
      if (!i1_tvalid && $urandom_range(0, 3) != 0) begin
        i1_tvalid = 1'b1; i1_tdata = rnd_beat(); i1_tlast = 1'($urandom_range(0, 1));
      end
      o_tready = ($urandom_range(0, 99) < pct);
    end
    drain("rand_drain");

`ifdef ADD2_AND_CLIP_SAT_COUNT_EN
    // Counter limits: preload one below the maximum, then saturate and clear.
    force dut.sat_cnt_q = 32'hFFFF_FFFE;
    sat_exp = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.sat_cnt_q;
    tick();
    for (int k = 0; k < 3; k++) send_beat({16'h7000, 16'h7000}, {16'h7000, 16'h7000}, 1'b0);
    drain("sat_drain");
    @(negedge clk); chk("sat_max", sat_count, 32'hFFFF_FFFF);
    tick();
    send_beat({16'h8000, 16'h0001}, {16'h8000, 16'h0001}, 1'b0);
    tick();
    sat_clr = 1'b1;
    @(negedge clk); chk("satclr_beat_valid", o_tvalid & o_tready, 1);
    tick();
    sat_clr = 1'b0;
    @(negedge clk); chk("satclr_priority", sat_count, 0);
    tick();
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
